// File: rtl/interrupt_capture.sv
// Captures the debug register value on each rising edge of the core's interrupt into a
// FWFT FIFO with a sequence tag. Define INTCAP_TIMESTAMP_EN to add per-entry cycle stamps.
module interrupt_capture #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned REG_SEL    = 25,
  parameter int unsigned SEQ_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [4:0]               reg_addr,
  input  logic [DATA_WIDTH-1:0]    reg_data,
  input  logic                     interrupt,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [SEQ_WIDTH-1:0]     out_seq,
  output logic [31:0]              out_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic                  int_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic                  overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEQ_WIDTH-1:0]  out_seq_q, out_seq_d;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [SEQ_WIDTH-1:0]  seq_mem  [DEPTH];

  logic                  event_c;
  logic                  pop_c;
  logic                  full_c;
  logic                  push_c;
  logic [CW-1:0]         remain_c;

  assign reg_addr = 5'(REG_SEL);

  assign event_c  = interrupt & ~int_q;
  assign pop_c    = out_valid_q & out_ready;
  assign full_c   = (count_q == CW'(DEPTH));
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push_c   = event_c & ~clear & (~full_c | pop_c);
  // Entries that were already stored before this edge and survive the pop; only these
  // may be loaded into the head register, which gives the one-cycle push-to-head latency.
  assign remain_c = count_q - CW'(pop_c);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    seq_d       = seq_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_seq_d   = out_seq_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      seq_d       = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
      if (event_c) begin
        seq_d = seq_q + SEQ_WIDTH'(1);
      end
      if (event_c && full_c && !pop_c) begin
        overflow_d = 1'b1;
      end
      out_valid_d = (remain_c != '0);
      if (out_valid_d) begin
        out_data_d = data_mem[rd_ptr_d];
        out_seq_d  = seq_mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      seq_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_seq_q   <= '0;
    end else begin
      int_q       <= interrupt;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      seq_q       <= seq_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_seq_q   <= out_seq_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      data_mem[wr_ptr_q] <= reg_data;
      seq_mem[wr_ptr_q]  <= seq_q;
    end
  end

`ifdef INTCAP_TIMESTAMP_EN
  logic [31:0] time_q;
  logic [31:0] out_time_q, out_time_d;
  logic [31:0] time_mem [DEPTH];

  always_comb begin
    out_time_d = out_time_q;
    if (out_valid_d) begin
      out_time_d = time_mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_q     <= '0;
      out_time_q <= '0;
    end else begin
      time_q     <= clear ? 32'd0 : time_q + 32'd1;
      out_time_q <= out_time_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      time_mem[wr_ptr_q] <= time_q;
    end
  end

  assign out_time = out_time_q;
`else
  assign out_time = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_seq   = out_seq_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_interrupt_capture.sv
// Scoreboard bench for interrupt_capture: a queue-based reference model predicts every
// entry, occupancy and overflow; a negedge monitor compares the DUT against it.
module tb_interrupt_capture;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic        interrupt;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_seq;
  logic [31:0] out_time;
  logic [4:0]  count;
  logic        overflow;

  interrupt_capture dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .interrupt (interrupt),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .out_time  (out_time),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one queue entry per accepted capture, with the edge index it was pushed on.
  typedef struct {
    logic [31:0] data;
    logic [7:0]  seq;
    logic [31:0] ts;
    int          cyc;
  } ent_t;

  ent_t        mq[$];
  ent_t        ent;
  logic [7:0]  m_seq;
  logic        m_ovf;
  logic        m_int;
  logic [31:0] m_time;
  int          cyc;
  bit          m_ev, m_pop, m_full, mon_valid;

  // An entry pushed at edge c becomes the visible head from edge c+2 onwards.
  function automatic bit head_visible();
    return (mq.size() > 0) && (mq[0].cyc + 1 < cyc);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_seq  = 8'd0;
      m_ovf  = 1'b0;
      m_int  = 1'b0;
      m_time = 32'd0;
      cyc    = 0;
    end else begin
      m_ev   = interrupt && !m_int;
      m_int  = interrupt;
      m_pop  = head_visible() && out_ready;
      m_full = (mq.size() == DEPTH);
      if (clear) begin
        mq.delete();
        m_seq  = 8'd0;
        m_ovf  = 1'b0;
        m_time = 32'd0;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_ev) begin
          if (m_full && !m_pop) begin
            m_ovf = 1'b1;
          end else begin
            ent.data = reg_data;
            ent.seq  = m_seq;
            ent.ts   = m_time;
            ent.cyc  = cyc;
            mq.push_back(ent);
          end
          m_seq = m_seq + 8'd1;
        end
        m_time = m_time + 32'd1;
      end
      cyc++;
    end
  end

  // Monitor: compare state every cycle and the head entry whenever one is presented.
  always @(negedge clk) begin
    mon_valid = head_visible();
    check("reg_addr", 64'(reg_addr), 64'd25);
    check("count", 64'(count), 64'(mq.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("out_valid", 64'(out_valid), 64'(mon_valid));
    if (out_valid && mon_valid) begin
      check("out_data", 64'(out_data), 64'(mq[0].data));
      check("out_seq", 64'(out_seq), 64'(mq[0].seq));
`ifdef INTCAP_TIMESTAMP_EN
      check("out_time", 64'(out_time), 64'(mq[0].ts));
`endif
    end
`ifndef INTCAP_TIMESTAMP_EN
    check("out_time_zero", 64'(out_time), 64'd0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [31:0] v);
    reg_data  = v;
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [31:0] t0, t1;
  int          bias;

  initial begin
    reset_n   = 1'b0;
    interrupt = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    reg_data  = 32'd0;
    repeat (3) tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_seq", 64'(out_seq), 64'd0);
    check("rst_time", 64'(out_time), 64'd0);
    reset_n = 1'b1;
    tick();

    // Three spaced pulses, then drain.
    for (int i = 0; i < 3; i++) begin
      reg_data  = 32'(15 + 5 * i);
      interrupt = 1'b1;
      tick();
      interrupt = 1'b0;
      repeat (9) tick();
    end
    check("three_count", 64'(count), 64'd3);
    check("three_head", 64'(out_data), 64'd15);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("three_drained_valid", 64'(out_valid), 64'd0);

    // Held level gives a single entry.
    do_clear();
    reg_data  = 32'd9;
    interrupt = 1'b1;
    repeat (20) tick();
    interrupt = 1'b0;
    tick();
    check("level_count", 64'(count), 64'd1);
    check("level_data", 64'(out_data), 64'd9);
    check("level_seq", 64'(out_seq), 64'd0);

    // Overfill: 18 events into 16 slots.
    do_clear();
    for (int i = 1; i <= 18; i++) fire(32'(i));
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    repeat (16) tick();
    out_ready = 1'b0;
    check("ovf_drained", 64'(count), 64'd0);
    fire(32'd99);
    check("ovf_next_data", 64'(out_data), 64'd99);
    check("ovf_next_seq", 64'(out_seq), 64'd18);

    // Event coincident with a pop while full.
    do_clear();
    for (int i = 1; i <= 16; i++) fire(32'(i));
    reg_data  = 32'd27;
    interrupt = 1'b1;
    out_ready = 1'b1;
    tick();
    interrupt = 1'b0;
    out_ready = 1'b0;
    check("fullpop_count", 64'(count), 64'd16);
    check("fullpop_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    repeat (15) tick();
    check("fullpop_last", 64'(out_data), 64'd27);
    tick();
    out_ready = 1'b0;
    check("fullpop_empty", 64'(count), 64'd0);

    // Clear in the same cycle as an event.
    do_clear();
    for (int i = 0; i < 5; i++) fire(32'(100 + i));
    reg_data  = 32'd77;
    interrupt = 1'b1;
    clear     = 1'b1;
    tick();
    clear     = 1'b0;
    interrupt = 1'b0;
    tick();
    check("clr_count", 64'(count), 64'd0);
    check("clr_overflow", 64'(overflow), 64'd0);
    fire(32'd44);
    check("clr_next_seq", 64'(out_seq), 64'd0);
    check("clr_next_data", 64'(out_data), 64'd44);

    // Two captures exactly 40 cycles apart.
    do_clear();
    fire(32'd1);
    repeat (38) tick();
    fire(32'd2);
    check("ts_count", 64'(count), 64'd2);
    t0 = out_time;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    t1 = out_time;
`ifdef INTCAP_TIMESTAMP_EN
    check("ts_delta", 64'(t1 - t0), 64'd40);
`else
    check("ts_off_first", 64'(t0), 64'd0);
    check("ts_off_second", 64'(t1), 64'd0);
`endif

    // Asynchronous reset mid-operation, released with interrupt already high.
    do_clear();
    for (int i = 0; i < 3; i++) fire(32'(200 + i));
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    interrupt = 1'b1;
    reg_data  = 32'd55;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("rst_edge_count", 64'(count), 64'd1);
    check("rst_edge_seq", 64'(out_seq), 64'd0);
    check("rst_edge_data", 64'(out_data), 64'd55);
    interrupt = 1'b0;

    // Randomized traffic with alternating consumer speed.
    for (int i = 0; i < 3000; i++) begin
      bias      = ((i / 400) % 2 == 1) ? 85 : 15;
      interrupt = ($urandom_range(0, 99) < 40);
      reg_data  = $urandom;
      out_ready = ($urandom_range(0, 99) < bias);
      clear     = ($urandom_range(0, 299) == 0);
      tick();
    end
    interrupt = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    check("final_empty", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
